spi_slave_if: RTL and testbench

SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) that sits at the far end of an SPI link driven by an external master. SCLK, CS_N and MOSI are asynchronous to the system clock. They are 2-FF synchronized, and the responder uses edge detection on the synchronized signals. The system side exchanges words through a valid/ready transmit handshake and a one-cycle receive strobe.

---
 rtl/spi_slave_if.sv | 167 ++++++++++++++++
 tb/tb_spi_slave_if.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Brief    : SPI mode-0 responder, pins resynchronised into the clk domain
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_if #(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              underrun,
    output logic              busy
);

    localparam int                 c_CNT_W  = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(DATA_W - 1);
    localparam logic [0:0]         c_IDLE   = 1'b0;
    localparam logic [0:0]         c_ACTIVE = 1'b1;

    logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic              r_cs_s1, r_cs_s2, r_cs_d;
    logic              r_mosi_s1, r_mosi_s2;
    logic [0:0]        r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic              r_word_done;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-2:0] r_rx_shift;
    logic [DATA_W-1:0] r_tx_buf;
    logic              r_tx_full;
    logic              w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic              w_load, w_shift, w_sample, w_abort, w_accept;
    logic [DATA_W-1:0] w_load_word;
    logic [DATA_W-1:0] w_rx_word;

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_d;

    assign tx_ready    = ~r_tx_full;
    assign w_accept    = tx_valid & ~r_tx_full;
    assign w_load_word = r_tx_full ? r_tx_buf : IDLE_WORD;
    assign w_rx_word   = {r_rx_shift, r_mosi_s2};
    assign busy        = (r_state == c_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // cs_rise takes priority over any sclk edge seen in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_sample    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = c_ACTIVE;
                    w_load      = 1'b1;
                end
            end
            c_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = c_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_sample = w_sclk_rise;
                    if (w_sclk_fall) begin
                        if (r_word_done) w_load  = 1'b1;
                        else             w_shift = 1'b1;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_s1   <= 1'b0;
            r_sclk_s2   <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_cs_s1     <= 1'b1;
            r_cs_s2     <= 1'b1;
            r_cs_d      <= 1'b1;
            r_mosi_s1   <= 1'b0;
            r_mosi_s2   <= 1'b0;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_tx_buf    <= '0;
            r_tx_full   <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_cs_s1   <= cs_n;
            r_cs_s2   <= r_cs_s1;
            r_cs_d    <= r_cs_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;

            // A load in the same cycle as an accept sees the buffer as it was
            if (w_accept) r_tx_buf <= tx_data;
            if (w_load)        r_tx_full <= w_accept;
            else if (w_accept) r_tx_full <= 1'b1;

            if (w_load) begin
                r_tx_shift  <= w_load_word;
                miso        <= w_load_word[DATA_W-1];
                underrun    <= ~r_tx_full;
                miso_oe     <= 1'b1;
                r_word_done <= 1'b0;
            end

            if (w_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                miso       <= r_tx_shift[DATA_W-2];
            end

            if (w_sample) begin
                r_rx_shift <= w_rx_word[DATA_W-2:0];
                if (r_bit_cnt == c_LAST) begin
                    rx_data     <= w_rx_word;
                    rx_valid    <= 1'b1;
                    r_bit_cnt   <= '0;
                    r_word_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_abort) begin
                r_bit_cnt   <= '0;
                r_word_done <= 1'b0;
                r_rx_shift  <= '0;
                miso_oe     <= 1'b0;
                miso        <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_if
// Brief    : Self-checking bench, SPI master model plus rx/miso scoreboards
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, cs_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, underrun, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rxv_cnt  = 0;
    int ur_cnt   = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];

    spi_slave_if #(
        .DATA_W    (8),
        .IDLE_WORD (8'hFF)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .underrun (underrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_miso(input logic [7:0] got);
        check_eq("miso_expected", 32'(exp_miso.size() != 0), 1);
        if (exp_miso.size() != 0) check_eq("miso_word", got, exp_miso.pop_front());
    endtask

    // Receive-side scoreboard: each rx_valid pops the word the master sent
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                rxv_cnt++;
                check_eq("rx_expected", 32'(exp_rx.size() != 0), 1);
                if (exp_rx.size() != 0) check_eq("rx_data", rx_data, exp_rx.pop_front());
            end
            if (underrun) ur_cnt++;
        end
    end

    task automatic push_tx(input logic [7:0] w);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_tx_ready_timeout", 32'(n < 200), 1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Master sends nbits MSB first at clk/16; with last set, the final sclk
    // fall and cs_n rise happen together, so no trailing load point occurs.
    task automatic send_bits(input logic [7:0] tx, input int nbits, input bit last,
                             output logic [7:0] got);
        got = 8'h00;
        if (nbits == 8) exp_rx.push_back(tx);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            got[7-i] = miso;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            if (last && i == nbits - 1) cs_n = 1'b1;
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [7:0] got;
        int rxv0, ur0, ready_idx, nready, held_ready;

        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_miso", miso, 0);
        check_eq("rst_miso_oe", miso_oe, 0);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_underrun_cnt", ur_cnt, 0);

        // Basic exchange
        push_tx(8'hA5);
        check_eq("basic_tx_ready_full", tx_ready, 0);
        exp_miso.push_back(8'hA5);
        rxv0 = rxv_cnt; ur0 = ur_cnt;
        cs_low();
        check_eq("basic_tx_ready_after_load", tx_ready, 1);
        check_eq("basic_miso_oe", miso_oe, 1);
        check_eq("basic_busy", busy, 1);
        check_eq("basic_miso_msb", miso, 1);
        send_bits(8'h3C, 8, 1, got);
        check_miso(got);
        check_eq("basic_rx_pulses", rxv_cnt - rxv0, 1);
        check_eq("basic_underrun", ur_cnt - ur0, 0);
        check_eq("basic_rx_data", rx_data, 8'h3C);
        check_eq("basic_miso_oe_off", miso_oe, 0);

        // Back-to-back words under one cs_n assertion
        push_tx(8'h12);
        exp_miso.push_back(8'h12);
        exp_miso.push_back(8'h34);
        rxv0 = rxv_cnt; ur0 = ur_cnt;
        cs_low();
        push_tx(8'h34);
        check_eq("b2b_tx_ready_full", tx_ready, 0);
        send_bits(8'hF0, 8, 0, got);
        check_miso(got);
        check_eq("b2b_tx_ready_after_2nd_load", tx_ready, 1);
        send_bits(8'h0F, 8, 1, got);
        check_miso(got);
        check_eq("b2b_rx_pulses", rxv_cnt - rxv0, 2);
        check_eq("b2b_underrun", ur_cnt - ur0, 0);

        // Underrun
        exp_miso.push_back(8'hFF);
        ur0 = ur_cnt;
        cs_low();
        check_eq("ur_at_cs_fall", ur_cnt - ur0, 1);
        send_bits(8'h55, 8, 1, got);
        check_miso(got);
        check_eq("ur_total", ur_cnt - ur0, 1);
        check_eq("ur_rx_data", rx_data, 8'h55);

        // Abort after 5 bits, then a full word
        rxv0 = rxv_cnt;
        cs_low();
        send_bits(8'hE7, 5, 1, got);
        check_eq("abort_no_rx_valid", rxv_cnt - rxv0, 0);
        check_eq("abort_rx_data_held", rx_data, 8'h55);
        check_eq("abort_miso_oe", miso_oe, 0);
        check_eq("abort_miso", miso, 0);
        check_eq("abort_busy", busy, 0);
        exp_miso.push_back(8'hFF);
        cs_low();
        send_bits(8'h81, 8, 1, got);
        check_miso(got);
        check_eq("abort_next_rx_data", rx_data, 8'h81);

        // Handshake: held tx_valid is refused while the buffer is full
        push_tx(8'hA7);
        check_eq("hs_tx_ready_full", tx_ready, 0);
        @(negedge clk);
        tx_data = 8'h99; tx_valid = 1'b1;
        held_ready = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_ready) held_ready++;
        end
        check_eq("hs_not_ready_while_full", held_ready, 0);
        cs_n = 1'b0;
        ready_idx = -1; nready = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (tx_ready) begin
                nready++;
                if (ready_idx < 0) ready_idx = k;
            end
        end
        tx_valid = 1'b0;
        check_eq("hs_ready_cycle", ready_idx, 3);
        check_eq("hs_ready_pulses", nready, 1);
        exp_miso.push_back(8'hA7);
        send_bits(8'h3A, 8, 1, got);
        check_miso(got);
        exp_miso.push_back(8'h99);
        cs_low();
        send_bits(8'h66, 8, 1, got);
        check_miso(got);

        // Reset in the middle of a word with cs_n held low
        push_tx(8'h6B);
        cs_low();
        push_tx(8'h77);
        send_bits(8'hA0, 3, 0, got);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("mid_rst_miso", miso, 0);
        check_eq("mid_rst_miso_oe", miso_oe, 0);
        check_eq("mid_rst_rx_data", rx_data, 0);
        check_eq("mid_rst_rx_valid", rx_valid, 0);
        check_eq("mid_rst_underrun", underrun, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        ur0 = ur_cnt;
        repeat (8) @(negedge clk);
        check_eq("post_mid_rst_busy", busy, 1);
        check_eq("post_mid_rst_miso_oe", miso_oe, 1);
        check_eq("post_mid_rst_underrun", ur_cnt - ur0, 1);
        exp_miso.push_back(8'hFF);
        send_bits(8'hC3, 8, 1, got);
        check_miso(got);
        check_eq("post_mid_rst_rx_data", rx_data, 8'hC3);

        check_eq("rx_queue_drained", exp_rx.size(), 0);
        check_eq("miso_queue_drained", exp_miso.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
